// File: rtl/tlc_pkg.sv
// Shared lamp encodings for tlc and the country-road sensor conditioner.
// Also holds the request FSM state type used by cntry_sensor_cond.
package tlc_pkg;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVED
  } sensor_state_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser, free-running sample tick and tick-based debouncer.
// Ports: clk, clr (async active-low), sensor_raw in; sensor_db, tick out.
module sync_debounce #(
  parameter int TICK_DIV       = 16,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic sensor_raw,
  output logic sensor_db,
  output logic tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  logic          s1;
  logic          sync_s;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] dcnt;

  assign tick = (tcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1     <= 1'b0;
      sync_s <= 1'b0;
    end else begin
      s1     <= sensor_raw;
      sync_s <= s1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // The flip happens on the tick that would bring dcnt to
  // DEBOUNCE_TICKS, so the counter never holds that value.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dcnt      <= '0;
      sensor_db <= 1'b0;
    end else if (tick) begin
      if (sync_s != sensor_db) begin
        if (dcnt == DW'(DEBOUNCE_TICKS - 1)) begin
          sensor_db <= ~sensor_db;
          dcnt      <= '0;
        end else begin
          dcnt <= dcnt + DW'(1);
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cntry_sensor_cond.sv
// Conditions the country-road loop sensor into the car-waiting input X of tlc.
// Ports: clk, clr (async active-low), sensor_raw, cntry[1:0] in;
// X, sensor_db out; sensor_fault out only with CNTRY_SENSOR_STUCK_EN.
module cntry_sensor_cond
  import tlc_pkg::*;
#(
  parameter int TICK_DIV       = 16,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int STUCK_TICKS    = 1024
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       sensor_raw,
  input  logic [1:0] cntry,
  output logic       X,
  output logic       sensor_db
`ifdef CNTRY_SENSOR_STUCK_EN
  ,
  output logic       sensor_fault
`endif
);

  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 ||
      STUCK_TICKS < 1) begin : g_bad_param
    $error("cntry_sensor_cond: bad parameter");
  end

  logic          tick;
  logic          sensor_db_q;
  logic          rise;
  logic          green;
  logic          fault;
  sensor_state_t state;
  sensor_state_t next_state;

  sync_debounce #(
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_sd (
    .clk        (clk),
    .clr        (clr),
    .sensor_raw (sensor_raw),
    .sensor_db  (sensor_db),
    .tick       (tick)
  );

`ifdef CNTRY_SENSOR_STUCK_EN
  localparam int SW = $clog2(STUCK_TICKS + 1);

  logic [SW-1:0] scnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      scnt <= '0;
    end else if (!sensor_db) begin
      scnt <= '0;
    end else if (tick && !fault) begin
      scnt <= scnt + SW'(1);
    end
  end

  assign fault        = (scnt == SW'(STUCK_TICKS));
  assign sensor_fault = fault;
`else
  logic unused_tick;

  assign unused_tick = tick;
  assign fault       = 1'b0;
`endif

  assign rise  = sensor_db & ~sensor_db_q;
  assign green = (cntry == LAMP_GREEN);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sensor_db_q <= 1'b0;
      state       <= IDLE;
      X           <= 1'b0;
    end else begin
      sensor_db_q <= sensor_db;
      state       <= next_state;
      X           <= (next_state == REQ);
    end
  end

  // A rise seen during country green is already being served,
  // so it goes straight to SERVED without raising X.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (rise) next_state = green ? SERVED : REQ;
      end
      REQ: begin
        if (green) next_state = SERVED;
      end
      SERVED: begin
        if (!green) next_state = sensor_db ? REQ : IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (fault) next_state = IDLE;
  end

endmodule

// File: tb/tb_cntry_sensor_cond.sv
// Directed bench for cntry_sensor_cond with TICK_DIV=4, DEBOUNCE_TICKS=3.
// Stuck-sensor checks run only when CNTRY_SENSOR_STUCK_EN is defined.
module tb_cntry_sensor_cond;
  import tlc_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic       sensor_raw;
  logic [1:0] cntry;
  logic       X;
  logic       sensor_db;
`ifdef CNTRY_SENSOR_STUCK_EN
  logic       sensor_fault;
`endif

  int n_chk = 0;
  int n_err = 0;
  int n;
  int m;
  logic hi;

  cntry_sensor_cond #(
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .STUCK_TICKS    (8)
  ) u_dut (
    .clk          (clk),
    .clr          (clr),
    .sensor_raw   (sensor_raw),
    .cntry        (cntry),
    .X            (X),
    .sensor_db    (sensor_db)
`ifdef CNTRY_SENSOR_STUCK_EN
    ,
    .sensor_fault (sensor_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_db(input logic lvl,
                         input int max,
                         output int cnt);
    cnt = 0;
    while (cnt < max && sensor_db !== lvl) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    clr        = 1'b0;
    sensor_raw = 1'b1;
    cntry      = LAMP_RED;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(X), 0);
    check("rst_db", 32'(sensor_db), 0);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_x", 32'(X), 0);
    check("rel_db", 32'(sensor_db), 0);

    // clean arrival
    wait_db(1'b1, 30, n);
    n = n + 2;
    check("arr_db", 32'(sensor_db), 1);
    check("arr_lat", 32'(n >= 9 && n <= 18), 1);
    check("arr_x_pre", 32'(X), 0);
    @(negedge clk);
    check("arr_x", 32'(X), 1);

    // request latched while car leaves
    sensor_raw = 1'b0;
    wait_db(1'b0, 30, n);
    check("fall_db", 32'(sensor_db), 0);
    check("hold_x", 32'(X), 1);

    // service
    cntry = LAMP_GREEN;
    @(negedge clk);
    check("srv_x", 32'(X), 0);
    cntry = LAMP_YELLOW;
    repeat (3) @(negedge clk);
    check("idle_x", 32'(X), 0);
    check("idle_st", 32'(u_dut.state), 32'(IDLE));
    cntry = LAMP_RED;

    // glitch of two ticks
    sensor_raw = 1'b1;
    repeat (8) @(negedge clk);
    sensor_raw = 1'b0;
    hi = 1'b0;
    repeat (24) begin
      @(negedge clk);
      if (sensor_db || X) hi = 1'b1;
    end
    check("glitch_out", 32'(hi), 0);
    check("glitch_dcnt", 32'(u_dut.u_sd.dcnt), 0);

    // re-request after green ends with car present
    sensor_raw = 1'b1;
    wait_db(1'b1, 30, n);
    check("rr_db", 32'(sensor_db), 1);
    @(negedge clk);
    check("rr_x1", 32'(X), 1);
    cntry = LAMP_GREEN;
    @(negedge clk);
    check("rr_srv", 32'(X), 0);
    repeat (2) @(negedge clk);
    check("rr_st", 32'(u_dut.state), 32'(SERVED));
    cntry = LAMP_YELLOW;
    @(negedge clk);
    check("rr_x2", 32'(X), 1);

    // async reset while requesting
    #2 clr = 1'b0;
    #1;
    check("arst_x", 32'(X), 0);
    check("arst_db", 32'(sensor_db), 0);
    @(negedge clk);
    clr   = 1'b1;
    cntry = LAMP_RED;
    repeat (5) @(negedge clk);
    check("arst_norise", 32'(X), 0);
    wait_db(1'b1, 30, n);
    @(negedge clk);
    check("arst_fresh", 32'(X), 1);

    // rise during country green raises no request
    clr   = 1'b0;
    cntry = LAMP_GREEN;
    @(negedge clk);
    clr = 1'b1;
    wait_db(1'b1, 30, n);
    check("grn_db", 32'(sensor_db), 1);
    repeat (3) @(negedge clk);
    check("grn_x", 32'(X), 0);
    check("grn_st", 32'(u_dut.state), 32'(SERVED));
    cntry = LAMP_RED;
    @(negedge clk);
    check("grn_rereq", 32'(X), 1);

`ifdef CNTRY_SENSOR_STUCK_EN
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    wait_db(1'b1, 30, n);
    @(negedge clk);
    check("stk_x_pre", 32'(X), 1);
    check("stk_f_pre", 32'(sensor_fault), 0);
    m = 1;
    while (m < 60 && sensor_fault !== 1'b1) begin
      @(negedge clk);
      m++;
    end
    check("stk_fault", 32'(sensor_fault), 1);
    check("stk_lat", 32'(m >= 28 && m <= 36), 1);
    @(negedge clk);
    check("stk_x", 32'(X), 0);
    sensor_raw = 1'b0;
    wait_db(1'b0, 30, n);
    @(negedge clk);
    check("stk_clr", 32'(sensor_fault), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
